// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter: buffers host writes and launches one byte at a time.
// Latency: write at edge N, byte latched at N+1, tx_wr_en_out high the cycle after; full writes are dropped and flagged.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              ack_err,
    input  logic              err_clr,
    output logic [7:0]        tx_data_out,
    output logic              tx_wr_en_out,
    input  logic              tx_busy_in
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ACK_LIM  = TMR_W'(ACK_TIMEOUT);
    // A zero gap still spends one cycle in GAP.
    localparam logic [TMR_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : TMR_W'(GAP_CYCLES - 1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;
    logic              ack_err_q, ack_err_d;
    logic              push, pop, ack_evt;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign push      = wr_en & ~full;
    assign pop       = (state_q == S_IDLE) & ~empty & ~tx_busy_in;
    assign timer_inc = timer_q + TMR_W'(1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        ack_evt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy_in) begin
                    state_d = S_WAIT_LO;
                end else begin
                    timer_d = timer_inc;
                    // No acknowledge: drop the byte rather than retry.
                    if (timer_inc == ACK_LIM) begin
                        ack_evt = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy_in) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(push);
        rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(pop);
        overflow_d = (wr_en & full) | (overflow_q & ~err_clr);
        ack_err_d  = ack_evt | (ack_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            ack_err_q  <= ack_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign overflow     = overflow_q;
    assign ack_err      = ack_err_q;
    assign tx_data_out  = tx_data_q;
    assign tx_wr_en_out = (state_q == S_LAUNCH);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model and a launch monitor.
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int GAP_CYCLES  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_en = 1'b0;
    logic            err_clr = 1'b0;
    logic            full, empty, overflow, ack_err, tx_wr_en_out;
    logic [ADDR_W:0] count;
    logic [7:0]      tx_data_out;
    logic            tx_busy_in;

    int n_chk = 0;
    int n_fail = 0;

    // transmitter model: mode 0 answers each launch with busy for hold_len cycles, mode 1 never answers
    int   tx_mode = 0;
    int   hold_len = 50;
    int   busy_left = 0;
    logic mdl_busy = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy_in = mdl_busy | force_busy;

    logic [7:0] cap[$];
    int   busy_viol = 0;
    int   wide_viol = 0;
    int   gap_viol = 0;
    int   since_fall = 1000;
    logic prev_pulse = 1'b0;
    logic gap_chk = 1'b0;

    uart_tx_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .ack_err(ack_err),
        .err_clr(err_clr), .tx_data_out(tx_data_out), .tx_wr_en_out(tx_wr_en_out),
        .tx_busy_in(tx_busy_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_mode == 0 && tx_wr_en_out) begin
            mdl_busy  <= 1'b1;
            busy_left <= hold_len;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) mdl_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tx_wr_en_out) begin
            cap.push_back(tx_data_out);
            if (tx_busy_in) busy_viol++;
            if (prev_pulse) wide_viol++;
            if (gap_chk && since_fall < GAP_CYCLES) gap_viol++;
        end
        prev_pulse = tx_wr_en_out;
        since_fall = tx_busy_in ? 0 : since_fall + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int t = 0;
        while (cap.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("pulse_wait", 32'(cap.size() >= n), 32'd1);
    endtask

    logic [7:0] exp1 [5] = '{8'hA5, 8'h5A, 8'hCB, 8'hFF, 8'h00};

    initial begin
        int base;
        int nxt;
        int t;

        // reset state
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_wr_en", 32'(tx_wr_en_out), 32'd0);
        chk("rst_data", 32'(tx_data_out), 32'd0);
        rst = 1'b1;
        tick();

        // back-to-back writes, 50-cycle busy
        hold_len = 50;
        gap_chk  = 1'b1;
        base = cap.size();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        chk("lat_empty", 32'(empty), 32'd0);
        chk("lat_count", 32'(count), 32'd1);
        chk("lat_no_fallthru", 32'(tx_wr_en_out), 32'd0);
        wr_data = 8'h5A;
        tick();
        chk("lat_pulse", 32'(tx_wr_en_out), 32'd1);
        chk("lat_data", 32'(tx_data_out), 32'hA5);
        chk("b2b_count1", 32'(count), 32'd1);
        wr_data = 8'hCB;
        tick();
        chk("pulse_single", 32'(tx_wr_en_out), 32'd0);
        wr_data = 8'hFF;
        tick();
        wr_data = 8'h00;
        tick();
        wr_en = 1'b0;
        chk("b2b_count4", 32'(count), 32'd4);
        wait_pulses(base + 5, 2000);
        for (int i = 0; i < 5; i++) chk("b2b_byte", 32'(cap[base+i]), 32'(exp1[i]));
        chk("b2b_drained", 32'(count), 32'd0);
        repeat (70) tick();
        chk("b2b_pulses", 32'(cap.size()), 32'(base + 5));
        chk("b2b_busy_viol", 32'(busy_viol), 32'd0);
        chk("b2b_wide_viol", 32'(wide_viol), 32'd0);
        chk("b2b_gap_viol", 32'(gap_viol), 32'd0);
        gap_chk = 1'b0;

        // fill and overflow
        hold_len = 4;
        force_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i);
            tick();
            if (i == 15) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_count16", 32'(count), 32'd16);
                chk("fill_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        wr_en = 1'b0;
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_count_hold", 32'(count), 32'd16);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("fill_err_clr", 32'(overflow), 32'd0);
        base = cap.size();
        force_busy = 1'b0;
        wait_pulses(base + 16, 2000);
        for (int i = 0; i < 16; i++) chk("fill_byte", 32'(cap[base+i]), 32'(i));
        repeat (20) tick();
        chk("fill_dropped", 32'(cap.size()), 32'(base + 16));
        chk("fill_empty", 32'(empty), 32'd1);

        // wrap-around streaming
        gap_chk = 1'b1;
        hold_len = 3;
        base = cap.size();
        nxt = 0;
        t = 0;
        while ((nxt < 40 || cap.size() < base + 40) && t < 3000) begin
            if (nxt < 40 && count < 12) begin
                wr_en = 1'b1;
                wr_data = 8'(nxt);
                nxt++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            t++;
        end
        wr_en = 1'b0;
        chk("wrap_done", 32'(cap.size()), 32'(base + 40));
        for (int i = 0; i < 40; i++) chk("wrap_byte", 32'(cap[base+i]), 32'(i));
        chk("wrap_no_ovf", 32'(overflow), 32'd0);
        chk("wrap_gap_viol", 32'(gap_viol), 32'd0);
        gap_chk = 1'b0;
        repeat (20) tick();

        // acknowledge timeout
        tx_mode = 1;
        base = cap.size();
        wr_en = 1'b1;
        wr_data = 8'h3C;
        tick();
        wr_data = 8'h7E;
        tick();
        wr_en = 1'b0;
        chk("ack_pulse", 32'(tx_wr_en_out), 32'd1);
        chk("ack_pulse_data", 32'(tx_data_out), 32'h3C);
        repeat (ACK_TIMEOUT) tick();
        chk("ack_not_yet", 32'(ack_err), 32'd0);
        tick();
        chk("ack_err_set", 32'(ack_err), 32'd1);
        wait_pulses(base + 2, 100);
        chk("ack_byte0", 32'(cap[base]), 32'h3C);
        chk("ack_byte1", 32'(cap[base+1]), 32'h7E);
        repeat (20) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ack_err_clr", 32'(ack_err), 32'd0);
        tx_mode = 0;

        // full FIFO with a pop in the same cycle as a write
        hold_len = 4;
        force_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h40 + 8'(i);
            tick();
        end
        chk("cp_full", 32'(full), 32'd1);
        base = cap.size();
        force_busy = 1'b0;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("cp_count15", 32'(count), 32'd15);
        chk("cp_overflow", 32'(overflow), 32'd1);
        chk("cp_launch", 32'(tx_wr_en_out), 32'd1);
        chk("cp_launch_data", 32'(tx_data_out), 32'h40);
        wait_pulses(base + 16, 2000);
        chk("cp_last_byte", 32'(cap[base+15]), 32'h4F);
        repeat (20) tick();
        chk("cp_no_extra", 32'(cap.size()), 32'(base + 16));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // asynchronous reset while waiting for busy to fall
        hold_len = 50;
        wr_en = 1'b1;
        wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_data = 8'h33;
        tick();
        wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        t = 0;
        while (!tx_busy_in && t < 20) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("mr_pre_count", 32'(count), 32'd3);
        chk("mr_pre_data", 32'(tx_data_out), 32'h11);
        #2 rst = 1'b0;
        #1;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_wr_en", 32'(tx_wr_en_out), 32'd0);
        chk("mr_data", 32'(tx_data_out), 32'd0);
        #2 rst = 1'b1;
        base = cap.size();
        repeat (150) tick();
        chk("mr_no_pulses", 32'(cap.size()), 32'(base));
        chk("mr_count_after", 32'(count), 32'd0);
        chk("final_busy_viol", 32'(busy_viol), 32'd0);
        chk("final_wide_viol", 32'(wide_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer placed directly upstream of the UART transmitter in uart_top.
- Host logic writes bytes at any rate. The block queues them and drains them one at a time into the transmitter's tx_data_in / tx_wr_en handshake, pacing on tx_busy_out.
- Removes the need for software to poll busy between bytes. Flags overflow and a missing transmitter acknowledge.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 8, cycles to wait for tx_busy_in to rise after a launch.
- GAP_CYCLES, 4, idle cycles inserted after tx_busy_in falls, before the next launch.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe; sampled on each rising clk edge.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped.
- ack_err  output  1  sticky: transmitter failed to assert busy within ACK_TIMEOUT.
- err_clr  input  1  synchronous clear of overflow and ack_err.
- tx_data_out  output  8  drives uart_top tx_data_in.
- tx_wr_en_out  output  1  drives uart_top tx_wr_en; single-cycle pulse.
- tx_busy_in  input  1  from uart_top tx_busy_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - read and write pointers = 0, count = 0, full = 0, empty = 1.
  - overflow = 0, ack_err = 0.
  - tx_data_out = 8'h00, tx_wr_en_out = 0, state = IDLE, timer = 0.
  - Memory contents need not reset. Reset mid-transfer discards all queued bytes; the transmitter is reset separately.
- Storage:
  - Circular buffer with ADDR_W+1-bit pointers; the MSB distinguishes full from empty.
  - full and empty are derived from the registered pointers.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Write rules:
  - wr_en=1 with full=0: store wr_data at wr_ptr and increment wr_ptr.
  - wr_en=1 with full=1: byte dropped and overflow set. This holds even if a pop occurs in the same cycle.
- Pop and push in the same cycle: both take effect and count is unchanged.
- err_clr=1: overflow and ack_err cleared. A simultaneous new error event wins (flag set).
- FSM:
  - IDLE:
    - If empty=0 and tx_busy_in=0: latch tx_data_out = mem[rd_ptr], increment rd_ptr, go to LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH:
    - tx_wr_en_out = 1 for exactly this cycle; clear the timer; go to WAIT_HI.
  - WAIT_HI:
    - If tx_busy_in=1, go to WAIT_LO.
    - Otherwise increment the timer. When the timer reaches ACK_TIMEOUT, set ack_err and go to IDLE; the byte is counted as sent and is not retried.
  - WAIT_LO:
    - When tx_busy_in=0, clear the timer and go to GAP.
  - GAP:
    - Count GAP_CYCLES cycles, then go to IDLE.
    - GAP_CYCLES=0 means GAP lasts one cycle.
- Output timing:
  - tx_wr_en_out is 0 in every state except LAUNCH.
  - tx_data_out is held stable from its latch until the next IDLE launch.
- Latency: for a write at edge N into an empty FIFO with the FSM in IDLE and tx_busy_in=0:
  - empty=0 after edge N.
  - data latched at edge N+1.
  - tx_wr_en_out is high during the cycle after edge N+1; there is no fall-through.
- Ordering: strictly FIFO, including across pointer wrap-around.

Test Plan:
- Back-to-back writes with a transmitter model (busy rises 1 cycle after wr_en, held 50 cycles):
  - Stimulus: wr_en high 5 consecutive cycles with A5,5A,CB,FF,00.
  - Response: 5 single-cycle tx_wr_en_out pulses carrying those bytes in order; no pulse while tx_busy_in=1; at least GAP_CYCLES between busy fall and the next pulse; count returns to 0.
- Fill and overflow:
  - Stimulus: hold tx_busy_in=1, write 17 bytes 00..10.
  - Response: full=1 and count=16 after the 16th write; byte 10 dropped; overflow=1.
  - Then err_clr → overflow=0; release busy → bytes 00..0F emitted in order.
- Wrap-around:
  - Stimulus: stream 40 incrementing bytes, keeping occupancy between 1 and 16.
  - Response: output sequence 00..27 exact; no overflow.
- Ack timeout:
  - Stimulus: transmitter model never raises busy; write 8'h3C, 8'h7E.
  - Response: ack_err=1 ACK_TIMEOUT cycles after the first pulse; second byte 7E still launched.
- Reset mid-operation:
  - Stimulus: 3 bytes queued, FSM in WAIT_LO, pulse rst=0 asynchronously between edges.
  - Response: immediately count=0, empty=1, tx_wr_en_out=0, tx_data_out=00; no further pulses after release.
- Full with concurrent pop:
  - Stimulus: FIFO full; wr_en in the same cycle the IDLE launch pops a byte.
  - Response: write dropped, overflow=1, count=15.
